// File: rtl/lfsr12_checker.sv
// Purpose: acquires and tracks a 12-bit LFSR word stream, flywheels across errors, counts LOCKED mismatches.
// Latency: one cycle; each sample's effect appears on the registered outputs in the cycle after its edge.
// Backpressure: none; the block is always ready and in_valid=0 simply freezes all state.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - in_data is sampled on this edge
//   in_data    - received 12-bit pseudo-random word
//   clear      - synchronous clear of err_count (wins over a simultaneous increment)
//   locked     - high while state is LOCKED
//   err_pulse  - one-cycle flag per mismatch seen while LOCKED
//   err_count  - saturating count of LOCKED mismatches
//   expected   - predicted next word, NEXT(ref)
//   state      - HUNT=0, VERIFY=1, LOCKED=2
module lfsr12_checker #(
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned LOSS_N = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [11:0] expected,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_C = 4'(LOCK_N);
    localparam logic [3:0] LOSS_C = 4'(LOSS_N);

    // Sequence generator. The all-ones word is folded onto zero and zero
    // restarts at all-ones, so both words are part of the ordinary cycle.
    function automatic logic [11:0] next12(input logic [11:0] x);
        logic        lin;
        logic [11:0] y;
        if (x == 12'h000) begin
            next12 = 12'hfff;
        end else begin
            lin = x[6] ^ x[4] ^ x[1] ^ x[0];
            y   = {lin, x[11:1]};
            next12 = (y == 12'hfff) ? 12'h000 : y;
        end
    endfunction

    logic [11:0] ref_q;
    logic [3:0]  good_cnt;
    logic [3:0]  bad_cnt;

    logic [1:0]  state_nxt;
    logic [11:0] ref_nxt;
    logic [3:0]  good_nxt;
    logic [3:0]  bad_nxt;
    logic        mism;

    logic        locked_nxt;
    logic        err_pulse_nxt;
    logic [15:0] err_count_nxt;
    logic [11:0] expected_nxt;

    logic        match;
    logic [3:0]  good_inc;
    logic [3:0]  bad_inc;

    // expected always holds NEXT(ref_q), so it doubles as the comparator
    // reference and as the flywheel value.
    assign match    = (in_data == expected);
    assign good_inc = good_cnt + 4'd1;
    assign bad_inc  = bad_cnt + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            ref_q     <= 12'h000;
            good_cnt  <= 4'd0;
            bad_cnt   <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= 16'h0000;
            expected  <= 12'hfff;
        end else begin
            state     <= state_nxt;
            ref_q     <= ref_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
            err_count <= err_count_nxt;
            expected  <= expected_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        ref_nxt   = ref_q;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        mism      = 1'b0;
        if (in_valid) begin
            case (state)
                ST_HUNT: begin
                    ref_nxt   = in_data;
                    good_nxt  = 4'd0;
                    state_nxt = ST_VERIFY;
                end
                ST_VERIFY: begin
                    // A mismatch here just re-seeds from the received word.
                    ref_nxt = in_data;
                    if (match) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_C) begin
                            state_nxt = ST_LOCKED;
                            bad_nxt   = 4'd0;
                        end
                    end else begin
                        good_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        ref_nxt = in_data;
                        bad_nxt = 4'd0;
                    end else begin
                        // Flywheel: advance on our own prediction and drop the bad word.
                        ref_nxt = expected;
                        mism    = 1'b1;
                        bad_nxt = bad_inc;
                        if (bad_inc == LOSS_C) begin
                            state_nxt = ST_HUNT;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        locked_nxt    = (state_nxt == ST_LOCKED);
        err_pulse_nxt = mism;
        expected_nxt  = next12(ref_nxt);
        err_count_nxt = err_count;
        if (clear) begin
            err_count_nxt = 16'h0000;
        end else if (mism && (err_count != 16'hffff)) begin
            err_count_nxt = err_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_lfsr12_checker.sv
module tb_lfsr12_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [11:0] expected;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    lfsr12_checker #(.LOCK_N(4), .LOSS_N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input at the falling edge, then settle just past the rising edge.
    task automatic step(input logic v, input logic [11:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        #2;
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 12'h000;
        clear    = 1'b0;
        #12;
        chk("rst_state",     16'(state),     16'h0000);
        chk("rst_locked",    16'(locked),    16'h0000);
        chk("rst_err_pulse", 16'(err_pulse), 16'h0000);
        chk("rst_err_count", err_count,      16'h0000);
        chk("rst_expected",  16'(expected),  16'h0fff);

        // First edge after release with in_valid high is a normal HUNT sample.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'h001;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_state", 16'(state),    16'h0001);
        chk("next_001",         16'(expected), 16'h0800);
        step(1'b1, 12'h800, 1'b0);
        chk("next_800",         16'(expected), 16'h0400);
        chk("verify_state",     16'(state),    16'h0001);
        step(1'b1, 12'h03f, 1'b0);
        chk("next_03f",         16'(expected), 16'h081f);
        chk("reseed_state",     16'(state),    16'h0001);
        step(1'b1, 12'h7ff, 1'b0);
        chk("next_7ff",         16'(expected), 16'h03ff);
        chk("reseed_no_err",    err_count,     16'h0000);
        step(1'b0, 12'h123, 1'b0);
        chk("gap_expected",     16'(expected), 16'h03ff);
        chk("gap_state",        16'(state),    16'h0001);

        // Lock acquisition on consecutive cycles.
        do_reset();
        step(1'b1, 12'h000, 1'b0);
        chk("acq_seed_state", 16'(state), 16'h0001);
        step(1'b1, 12'hfff, 1'b0);
        step(1'b1, 12'h7ff, 1'b0);
        step(1'b1, 12'h3ff, 1'b0);
        chk("acq_3_locked",   16'(locked),   16'h0000);
        step(1'b1, 12'h1ff, 1'b0);
        chk("acq_locked",     16'(locked),   16'h0001);
        chk("acq_state",      16'(state),    16'h0002);
        chk("acq_expected",   16'(expected), 16'h00ff);
        chk("acq_err_count",  err_count,     16'h0000);

        // Lock ending on ref=3ff, then flywheel.
        do_reset();
        step(1'b1, 12'hffe, 1'b0);
        step(1'b1, 12'h000, 1'b0);
        step(1'b1, 12'hfff, 1'b0);
        step(1'b1, 12'h7ff, 1'b0);
        step(1'b1, 12'h3ff, 1'b0);
        chk("fly_pre_locked",   16'(locked),    16'h0001);
        chk("fly_pre_expected", 16'(expected),  16'h01ff);
        step(1'b1, 12'h123, 1'b0);
        chk("fly_err_pulse",    16'(err_pulse), 16'h0001);
        chk("fly_err_count",    err_count,      16'h0001);
        chk("fly_expected",     16'(expected),  16'h00ff);
        chk("fly_still_locked", 16'(locked),    16'h0001);
        step(1'b1, 12'h0ff, 1'b0);
        chk("fly_pulse_drop",   16'(err_pulse), 16'h0000);
        chk("fly_match_count",  err_count,      16'h0001);
        chk("fly_match_exp",    16'(expected),  16'h007f);
        step(1'b1, 12'h555, 1'b0);
        chk("mis2_count",       err_count,      16'h0002);
        chk("mis2_expected",    16'(expected),  16'h003f);
        // Clear together with a mismatch; lock holds only if bad was reset by the 0ff match.
        step(1'b1, 12'h555, 1'b1);
        chk("clr_count",        err_count,      16'h0000);
        chk("clr_pulse",        16'(err_pulse), 16'h0001);
        chk("clr_locked",       16'(locked),    16'h0001);
        chk("clr_expected",     16'(expected),  16'h081f);
        step(1'b1, 12'h81f, 1'b0);
        chk("post_clr_pulse",   16'(err_pulse), 16'h0000);
        chk("post_clr_exp",     16'(expected),  16'h0c0f);

        // Loss of lock after three consecutive wrong words.
        step(1'b1, 12'h0aa, 1'b0);
        chk("loss1_count",  err_count,   16'h0001);
        step(1'b1, 12'h0aa, 1'b0);
        chk("loss2_locked", 16'(locked), 16'h0001);
        step(1'b1, 12'h0aa, 1'b0);
        chk("loss3_count",  err_count,   16'h0003);
        chk("loss3_state",  16'(state),  16'h0000);
        chk("loss3_locked", 16'(locked), 16'h0000);

        // Relock with five words and in_valid gaps in between.
        step(1'b1, 12'h001, 1'b0);
        chk("relock_seed",   16'(state),    16'h0001);
        step(1'b0, 12'habc, 1'b0);
        step(1'b1, 12'h800, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        step(1'b1, 12'h400, 1'b0);
        step(1'b1, 12'h200, 1'b0);
        step(1'b0, 12'h100, 1'b0);
        chk("relock_gap",    16'(locked),   16'h0000);
        step(1'b1, 12'h100, 1'b0);
        chk("relock_locked", 16'(locked),   16'h0001);
        chk("relock_state",  16'(state),    16'h0002);
        chk("relock_exp",    16'(expected), 16'h0080);
        chk("relock_count",  err_count,     16'h0003);

        // Bring err_count to 5 while LOCKED, then reset asynchronously.
        step(1'b1, 12'h0aa, 1'b0);
        chk("e4_expected",   16'(expected), 16'h0040);
        step(1'b1, 12'h0aa, 1'b0);
        chk("e5_count",      err_count,     16'h0005);
        chk("e5_locked",     16'(locked),   16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state",     16'(state),     16'h0000);
        chk("arst_count",     err_count,      16'h0000);
        chk("arst_expected",  16'(expected),  16'h0fff);
        chk("arst_locked",    16'(locked),    16'h0000);
        chk("arst_err_pulse", 16'(err_pulse), 16'h0000);
        #1;
        rst_n = 1'b1;
        step(1'b1, 12'h010, 1'b0);
        chk("reacq_state",   16'(state),  16'h0001);
        chk("reacq_locked",  16'(locked), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
